// File: rtl/io_cond_pkg.sv
// Shared definitions for the button/switch input conditioner.
//   deb_state_e           - per-button debounce FSM state
//   DEBOUNCE_CYCLES_DEF   - default qualification length (10 ms at 50 MHz)
package io_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } deb_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: polarity normalisation, 2-flop synchronizer,
// debounce FSM with qualification counter, and press strobe.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_btn_raw      : raw asynchronous button
//   o_btn          : debounced level, 1 = pressed (registered)
//   o_pulse        : one-cycle strobe on the first pressed cycle (registered)
//
// state          | meaning
// ---------------+-----------------------------------------------
// ST_IDLE        | released, waiting for synchronized press
// ST_PRESS_CHK   | press seen, counting stable pressed samples
// ST_PRESSED     | debounced pressed, waiting for release
// ST_RELEASE_CHK | release seen, counting stable released samples
module btn_debounce_ch
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          INV      = (BTN_ACTIVE_LOW != 0);

  logic          sync1_q;
  logic          s_q;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          btn_q;
  logic          pulse_q;

  // Normalise before synchronizing so reset value 0 means "released".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= i_btn_raw ^ INV;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_q) begin
            state_q <= ST_PRESS_CHK;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_PRESS_CHK: begin
          if (!s_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
            btn_q   <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s_q) begin
            state_q <= ST_RELEASE_CHK;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_RELEASE_CHK: begin
          // A bounce back to pressed is not a new press: no strobe.
          if (s_q) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          btn_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_btn   = btn_q;
  assign o_pulse = pulse_q;

endmodule

// File: rtl/io_btn_sw_cond.sv
// Board input conditioner: debounces 4 pushbuttons and synchronizes
// 32 slide switches into the clock domain.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_btn_raw[3:0] : raw buttons (polarity set by BTN_ACTIVE_LOW)
//   i_sw_raw[31:0] : raw switches
//   o_io_btn[3:0]  : debounced button levels, 1 = pressed
//   o_btn_pulse    : one-cycle press strobes
//   o_io_sw[31:0]  : synchronized switches (no debounce)
module io_btn_sw_cond
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_btn_raw,
  input  logic [31:0] i_sw_raw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_pulse,
  output logic [31:0] o_io_sw
);

  logic [31:0] sw_sync1_q;
  logic [31:0] sw_sync2_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_btn_raw (i_btn_raw[gi]),
      .o_btn     (o_io_btn[gi]),
      .o_pulse   (o_btn_pulse[gi])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= i_sw_raw;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  assign o_io_sw = sw_sync2_q;

endmodule

// File: tb/tb_io_btn_sw_cond.sv
module tb_io_btn_sw_cond;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_raw = 4'hF;
  logic [31:0] sw_raw = '0;
  logic [3:0]  io_btn;
  logic [3:0]  btn_pulse;
  logic [31:0] io_sw;

  int checks = 0;
  int errors = 0;

  io_btn_sw_cond #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn_raw   (btn_raw),
    .i_sw_raw    (sw_raw),
    .o_io_btn    (io_btn),
    .o_btn_pulse (btn_pulse),
    .o_io_sw     (io_sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button's debounced level flips once the synchronized
  // sample has disagreed with it for D consecutive clock edges; the synchronizer
  // is a plain two-sample delay line.
  logic [3:0]  m_sync1 = '0;
  logic [3:0]  m_s     = '0;
  logic [3:0]  m_lvl   = '0;
  logic [3:0]  m_pulse = '0;
  int          m_run [4] = '{0, 0, 0, 0};
  logic [31:0] m_sw1 = '0;
  logic [31:0] m_sw2 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 <= '0;
      m_s     <= '0;
      m_lvl   <= '0;
      m_pulse <= '0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
      m_sw1   <= '0;
      m_sw2   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s[i] != m_lvl[i]) begin
          if (m_run[i] + 1 == D) begin
            m_lvl[i]   <= ~m_lvl[i];
            m_pulse[i] <= ~m_lvl[i];
            m_run[i]   <= 0;
          end else begin
            m_run[i]   <= m_run[i] + 1;
            m_pulse[i] <= 1'b0;
          end
        end else begin
          m_run[i]   <= 0;
          m_pulse[i] <= 1'b0;
        end
      end
      m_s     <= m_sync1;
      m_sync1 <= ~btn_raw;
      m_sw2   <= m_sw1;
      m_sw1   <= sw_raw;
    end
  end

  always @(negedge clk) begin
    chk("model_btn", {28'd0, io_btn}, {28'd0, m_lvl});
    chk("model_pulse", {28'd0, btn_pulse}, {28'd0, m_pulse});
    chk("model_sw", io_sw, m_sw2);
  end

  initial begin
    int hold [4];

    // reset state
    #3;
    chk("reset_btn", {28'd0, io_btn}, 32'd0);
    chk("reset_pulse", {28'd0, btn_pulse}, 32'd0);
    chk("reset_sw", io_sw, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // clean press of button 0
    btn_raw[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("press_k4_btn", {28'd0, io_btn}, 32'h0);
    @(negedge clk);
    chk("press_k5_btn", {28'd0, io_btn}, 32'h1);
    chk("press_k5_pulse", {28'd0, btn_pulse}, 32'h1);
    @(negedge clk);
    chk("press_k6_pulse", {28'd0, btn_pulse}, 32'h0);
    chk("press_k6_btn", {28'd0, io_btn}, 32'h1);

    // bouncing button 1
    for (int t = 0; t < 6; t++) begin
      btn_raw[1] = (t % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("bounce_btn1_low", {31'd0, io_btn[1]}, 32'd0);
      end
    end
    btn_raw[1] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bounce_m4_btn", {28'd0, io_btn}, 32'h1);
    @(negedge clk);
    chk("bounce_m5_btn", {28'd0, io_btn}, 32'h3);
    chk("bounce_m5_pulse", {28'd0, btn_pulse}, 32'h2);
    @(negedge clk);
    chk("bounce_m6_pulse", {28'd0, btn_pulse}, 32'h0);

    // release glitch on button 0
    btn_raw[0] = 1'b1;
    repeat (2) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("glitch_btn0", {31'd0, io_btn[0]}, 32'd1);
      chk("glitch_pulse", {28'd0, btn_pulse}, 32'd0);
    end

    // clean release of button 0
    btn_raw[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("release_k4_btn", {28'd0, io_btn}, 32'h3);
    @(negedge clk);
    chk("release_k5_btn", {28'd0, io_btn}, 32'h2);
    chk("release_k5_pulse", {28'd0, btn_pulse}, 32'h0);
    btn_raw[1] = 1'b1;
    repeat (10) @(negedge clk);
    chk("all_released", {28'd0, io_btn}, 32'h0);

    // switch synchronizer latency
    sw_raw = 32'hA5A5_0F0F;
    @(posedge clk);
    @(negedge clk);
    chk("sw_k0", io_sw, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("sw_k1", io_sw, 32'hA5A5_0F0F);

    // reset while button 2 is being qualified
    btn_raw[2] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_btn", {28'd0, io_btn}, 32'h0);
    chk("rst_async_pulse", {28'd0, btn_pulse}, 32'h0);
    chk("rst_async_sw", io_sw, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_k4_btn", {28'd0, io_btn}, 32'h0);
    @(negedge clk);
    chk("rst_k5_btn", {28'd0, io_btn}, 32'h4);
    chk("rst_k5_pulse", {28'd0, btn_pulse}, 32'h4);
    repeat (6) begin
      @(negedge clk);
      chk("rst_single_pulse", {28'd0, btn_pulse}, 32'h0);
    end

    // randomized activity on all buttons and switches
    for (int i = 0; i < 4; i++) hold[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12)
                                                : $urandom_range(1, 6);
        end
      end
      if ($urandom_range(0, 7) == 0) sw_raw = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_btn_sw_cond.md
IO_BTN_SW_COND -- requirements
Module: io_btn_sw_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable samples required (10 ms at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 1, meaning raw buttons read 0 when pressed.
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_btn_raw, input, 4 bits: asynchronous raw pushbuttons from the board.
REQ-006 SHALL have port i_sw_raw, input, 32 bits: asynchronous raw slide switches.
REQ-007 SHALL have port o_io_btn, output, 4 bits: debounced button level, 1 = pressed; it feeds the core's i_io_btn.
REQ-008 SHALL have port o_btn_pulse, output, 4 bits: a one-cycle press-event strobe per button.
REQ-009 SHALL have port o_io_sw, output, 32 bits: synchronized switches; it feeds the core's i_io_sw.

Function
REQ-010 SHALL normalize each raw button to active-high (XOR with BTN_ACTIVE_LOW) before a 2-flop synchronizer; the synchronized bit is s[i].
REQ-011 SHALL pass each switch bit through a 2-flop synchronizer only, with no debounce; a value captured at edge k appears on o_io_sw after edge k+1.
REQ-012 SHALL run one independent FSM per button, with states IDLE, PRESS_CHK, PRESSED and RELEASE_CHK, and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 IDLE SHALL hold o_io_btn[i]=0; s[i]=1 moves to PRESS_CHK with cnt=1.
REQ-014 PRESS_CHK:
- s[i]=0 returns to IDLE (cnt cleared).
- s[i]=1 with cnt==DEBOUNCE_CYCLES-1 moves to PRESSED.
- Otherwise cnt increments.
REQ-015 PRESSED SHALL hold o_io_btn[i]=1; s[i]=0 moves to RELEASE_CHK with cnt=1.
REQ-016 RELEASE_CHK:
- s[i]=1 returns to PRESSED (cnt cleared; no new pulse).
- s[i]=0 with cnt==DEBOUNCE_CYCLES-1 moves to IDLE.
- Otherwise cnt increments.
REQ-017 SHALL hold o_io_btn[i]=1 in PRESSED and RELEASE_CHK and 0 otherwise, all registered.
REQ-018 SHALL assert o_btn_pulse[i] for exactly one cycle, coincident with the first cycle o_io_btn[i] is 1; a release never pulses.
REQ-019 Latency for a bounce-free change first captured by the synchronizer at edge k: o_io_btn changes at edge k+DEBOUNCE_CYCLES+1.
REQ-020 Any bounce during a CHK state SHALL restart qualification; o_io_btn SHALL NOT glitch.
REQ-021 Simultaneous activity on several buttons SHALL be handled independently, with no cross-channel interaction.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL NOT wrap.

Reset
REQ-023 i_rst_n low SHALL immediately (asynchronously) force all FSMs to IDLE, counters to 0, all synchronizer flops to 0 (released/normalized), o_io_btn=0, o_btn_pulse=0 and o_io_sw=0.
REQ-024 A button held across reset deassertion SHALL require full requalification per REQ-019 before asserting; reset mid-count SHALL discard progress and emit no pulse.

Structure
REQ-025 Package io_cond_pkg SHALL hold the debounce FSM state enum and the DEBOUNCE_CYCLES default constant.
REQ-026 SHALL contain sub-module btn_debounce_ch (synchronizer, FSM, counter and pulse for one button), instantiated 4 times; the switch synchronizer is inline.

Verification (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-027 Clean press: i_btn_raw[0] 1->0 first captured at edge k, then held. Required: o_io_btn=4'b0001 from edge k+5; o_btn_pulse=4'b0001 for the single cycle after edge k+5; other bits stay 0.
REQ-028 Bounce: i_btn_raw[1] toggles every 2 cycles for 12 cycles, last transition (to 0) captured at edge m. Required: o_io_btn[1]=0 throughout the bounce, rising at edge m+5 with one pulse.
REQ-029 Release glitch: button 0 pressed, raw goes 1 for 2 cycles and then back to 0. Required: o_io_btn[0] stays 1 and no pulse.
REQ-030 Clean release captured at edge k. Required: o_io_btn[0] falls at edge k+5; o_btn_pulse stays 0.
REQ-031 Switches: i_sw_raw=32'hA5A5_0F0F captured at edge k. Required: o_io_sw=32'hA5A5_0F0F after edge k+1.
REQ-032 Reset mid-count: i_rst_n pulsed low while button 2 is in PRESS_CHK and the button stays held. Required: all outputs 0 immediately; after reset release, o_io_btn[2] rises 5 edges after the first post-reset capture edge with exactly one pulse.
